// File: rtl/dz_scan_driver.sv
// dz_scan_driver: double-buffered 8x8 dual-colour dot-matrix scanner.
// Game logic writes rows into the back bank; the scanner multiplexes the
// front bank onto row/colg/colr. Banks swap only at a frame boundary so a
// displayed frame never mixes old and new content.
module dz_scan_driver #(
  parameter int CLK_DIV = 5000,
  parameter int DIV_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_g,
  input  logic [7:0] wr_r,
  input  logic       swap_req,
  input  logic       blank,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [7:0] row,
  output logic [7:0] colg,
  output logic [7:0] colr
);

  // Each entry packs {green, red} for one row.
  logic [15:0]      bank0 [8];
  logic [15:0]      bank1 [8];
  logic             front_sel;
  logic             pending;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       row_idx;
  logic             wrap_p1;

  // Stage p0: decode of the current counter values.
  logic             last_div_p0;
  logic             frame_end_p0;
  logic             swap_now_p0;
  logic             show_p0;
  logic [15:0]      front_row_p0;
  logic [7:0]       row_sel_p0;

  // Combinational decode of scan phase, swap decision and front-bank read.
  always_comb begin
    last_div_p0  = (div_cnt == DIV_W'(CLK_DIV - 1));
    frame_end_p0 = last_div_p0 && (row_idx == 3'd7);
    swap_now_p0  = frame_end_p0 && (pending || swap_req);
    show_p0      = !blank && (div_cnt != '0);
    front_row_p0 = front_sel ? bank1[row_idx] : bank0[row_idx];
    row_sel_p0   = ~(8'd1 << row_idx);
  end

  // Back-bank writes; the bank chosen uses front_sel before this edge, so a
  // write on the swap edge lands in the bank that is about to be shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (wr_en) begin
      if (front_sel) bank0[wr_row] <= {wr_g, wr_r};
      else           bank1[wr_row] <= {wr_g, wr_r};
    end
  end

  // Row-period divider and row index; both run regardless of blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      row_idx <= 3'd0;
    end else if (last_div_p0) begin
      div_cnt <= '0;
      row_idx <= row_idx + 3'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Swap handshake: requests merge into one pending flag, honoured at the
  // frame boundary (including a request arriving in the boundary cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_sel <= 1'b0;
      pending   <= 1'b0;
      swap_ack  <= 1'b0;
    end else begin
      swap_ack <= swap_now_p0;
      if (swap_now_p0) begin
        front_sel <= ~front_sel;
        pending   <= 1'b0;
      end else if (swap_req) begin
        pending <= 1'b1;
      end
    end
  end

  // Stage p1: registered pin drive; phase 0 of each row period is dead time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row         <= 8'hFF;
      colg        <= 8'h00;
      colr        <= 8'h00;
      wrap_p1     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      row         <= show_p0 ? row_sel_p0 : 8'hFF;
      colg        <= show_p0 ? front_row_p0[15:8] : 8'h00;
      colr        <= show_p0 ? front_row_p0[7:0] : 8'h00;
      wrap_p1     <= frame_end_p0;
      frame_start <= wrap_p1;
    end
  end

endmodule

// File: tb/tb_dz_scan_driver.sv
// Directed testbench for dz_scan_driver with CLK_DIV=4 (32-cycle frames).
// Edge n counts clock edges since reset release; output after edge n shows
// div=(n-1)%4, row=((n-1)/4)%8. Frame f covers edges 32f+1..32f+32.
module tb_dz_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = 3'd0;
  logic [7:0] wr_g = 8'h00;
  logic [7:0] wr_r = 8'h00;
  logic       swap_req = 1'b0;
  logic       blank = 1'b0;
  logic       swap_ack;
  logic       frame_start;
  logic [7:0] row;
  logic [7:0] colg;
  logic [7:0] colr;

  int checks = 0;
  int failures = 0;
  int edges = 0;

  dz_scan_driver #(.CLK_DIV(4), .DIV_W(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_g(wr_g),
    .wr_r(wr_r), .swap_req(swap_req), .blank(blank), .swap_ack(swap_ack),
    .frame_start(frame_start), .row(row), .colg(colg), .colr(colr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic goto(input int n);
    while (edges < n) step();
  endtask

  task automatic test_reset();
    int fs_edge;
    step(); step();
    checks++; if (row !== 8'hFF || colg !== 8'h00 || colr !== 8'h00) begin failures++; $display("FAIL reset_hold row=%h colg=%h colr=%h exp FF/00/00", row, colg, colr); end
    checks++; if (swap_ack !== 1'b0 || frame_start !== 1'b0) begin failures++; $display("FAIL reset_hold_pulses ack=%b fs=%b exp 0/0", swap_ack, frame_start); end
    rst = 1'b0;
    edges = 0;
    goto(10);
    checks++; if (row !== 8'hFB) begin failures++; $display("FAIL pre_reset_row row=%h exp FB", row); end
    #3 rst = 1'b1;
    #1;
    checks++; if (row !== 8'hFF || colg !== 8'h00 || colr !== 8'h00 || swap_ack !== 1'b0) begin failures++; $display("FAIL async_reset row=%h colg=%h colr=%h ack=%b exp FF/00/00/0", row, colg, colr, swap_ack); end
    step(); step();
    rst = 1'b0;
    edges = 0;
    fs_edge = -1;
    while (edges < 40 && fs_edge < 0) begin
      step();
      if (frame_start === 1'b1) fs_edge = edges;
    end
    checks++; if (fs_edge != 33) begin failures++; $display("FAIL first_frame_start edge=%0d exp 33", fs_edge); end
  endtask

  task automatic test_empty();
    wr_en = 1'b1; wr_row = 3'd3; wr_g = 8'hA5; wr_r = 8'h0F;
    step();
    wr_en = 1'b0;
    goto(46);
    checks++; if (row !== 8'hF7 || colg !== 8'h00 || colr !== 8'h00) begin failures++; $display("FAIL empty_row3 row=%h colg=%h colr=%h exp F7/00/00", row, colg, colr); end
    goto(64);
    checks++; if (swap_ack !== 1'b0) begin failures++; $display("FAIL empty_no_ack ack=%b exp 0", swap_ack); end
  endtask

  task automatic test_swap_mid();
    int n_ack, ack_edge;
    goto(73);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    n_ack = 0; ack_edge = -1;
    while (edges < 97) begin
      step();
      if (swap_ack === 1'b1) begin n_ack++; ack_edge = edges; end
    end
    checks++; if (n_ack != 1 || ack_edge != 96) begin failures++; $display("FAIL swap_mid_ack count=%0d edge=%0d exp 1 at 96", n_ack, ack_edge); end
    goto(98);
    checks++; if (row !== 8'hFE || colg !== 8'h00) begin failures++; $display("FAIL swap_mid_row0 row=%h colg=%h exp FE/00", row, colg); end
    goto(109);
    checks++; if (row !== 8'hFF || colg !== 8'h00 || colr !== 8'h00) begin failures++; $display("FAIL swap_mid_deadtime row=%h colg=%h colr=%h exp FF/00/00", row, colg, colr); end
    goto(110);
    checks++; if (row !== 8'hF7 || colg !== 8'hA5 || colr !== 8'h0F) begin failures++; $display("FAIL swap_mid_row3a row=%h colg=%h colr=%h exp F7/A5/0F", row, colg, colr); end
    goto(112);
    checks++; if (row !== 8'hF7 || colg !== 8'hA5 || colr !== 8'h0F) begin failures++; $display("FAIL swap_mid_row3c row=%h colg=%h colr=%h exp F7/A5/0F", row, colg, colr); end
  endtask

  task automatic test_merged();
    int n_ack, ack_edge;
    n_ack = 0; ack_edge = -1;
    while (edges < 129) begin
      swap_req = (edges == 112 || edges == 116 || edges == 120);
      step();
      swap_req = 1'b0;
      if (swap_ack === 1'b1) begin n_ack++; ack_edge = edges; end
    end
    checks++; if (n_ack != 1 || ack_edge != 128) begin failures++; $display("FAIL merged_ack count=%0d edge=%0d exp 1 at 128", n_ack, ack_edge); end
  endtask

  task automatic test_boundary();
    int n_ack;
    n_ack = 0;
    while (edges < 159) begin
      step();
      if (swap_ack === 1'b1) n_ack++;
      if (edges == 142) begin
        checks++; if (row !== 8'hF7 || colg !== 8'h00) begin failures++; $display("FAIL merged_front row=%h colg=%h exp F7/00", row, colg); end
      end
    end
    checks++; if (n_ack != 0) begin failures++; $display("FAIL merged_no_reack count=%0d exp 0", n_ack); end
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    checks++; if (swap_ack !== 1'b1) begin failures++; $display("FAIL boundary_ack ack=%b exp 1", swap_ack); end
  endtask

  task automatic test_no_req();
    int n_ack;
    n_ack = 0;
    while (edges < 193) begin
      step();
      if (swap_ack === 1'b1) n_ack++;
      if (edges == 174) begin
        checks++; if (row !== 8'hF7 || colg !== 8'hA5 || colr !== 8'h0F) begin failures++; $display("FAIL boundary_front row=%h colg=%h colr=%h exp F7/A5/0F", row, colg, colr); end
      end
    end
    checks++; if (n_ack != 0) begin failures++; $display("FAIL no_req_ack count=%0d exp 0", n_ack); end
  endtask

  task automatic test_write_at_swap();
    goto(223);
    wr_en = 1'b1; wr_row = 3'd0; wr_g = 8'hFF; wr_r = 8'h00; swap_req = 1'b1;
    step();
    wr_en = 1'b0; swap_req = 1'b0;
    checks++; if (swap_ack !== 1'b1) begin failures++; $display("FAIL was_ack ack=%b exp 1", swap_ack); end
    goto(226);
    checks++; if (row !== 8'hFE || colg !== 8'hFF || colr !== 8'h00) begin failures++; $display("FAIL was_row0 row=%h colg=%h colr=%h exp FE/FF/00", row, colg, colr); end
    goto(238);
    checks++; if (row !== 8'hF7 || colg !== 8'h00) begin failures++; $display("FAIL was_row3 row=%h colg=%h exp F7/00", row, colg); end
    goto(240);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    goto(258);
    checks++; if (row !== 8'hFE || colg !== 8'h00) begin failures++; $display("FAIL was_back_row0 row=%h colg=%h exp FE/00", row, colg); end
    goto(270);
    checks++; if (row !== 8'hF7 || colg !== 8'hA5 || colr !== 8'h0F) begin failures++; $display("FAIL was_back_row3 row=%h colg=%h colr=%h exp F7/A5/0F", row, colg, colr); end
  endtask

  task automatic test_blank();
    int bad;
    goto(288);
    blank = 1'b1;
    bad = 0;
    while (edges < 320) begin
      step();
      if (row !== 8'hFF || colg !== 8'h00 || colr !== 8'h00) bad++;
      if (edges == 289) begin
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL blank_fs_289 fs=%b exp 1", frame_start); end
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL blank_hold lit_cycles=%0d exp 0", bad); end
    blank = 1'b0;
    step();
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL blank_fs_321 fs=%b exp 1", frame_start); end
    step();
    checks++; if (row !== 8'hFE || colg !== 8'h00) begin failures++; $display("FAIL blank_resume_row0 row=%h colg=%h exp FE/00", row, colg); end
    goto(330);
    checks++; if (row !== 8'hFB) begin failures++; $display("FAIL blank_resume_row2 row=%h exp FB", row); end
    goto(334);
    checks++; if (row !== 8'hF7 || colg !== 8'hA5 || colr !== 8'h0F) begin failures++; $display("FAIL blank_resume_row3 row=%h colg=%h colr=%h exp F7/A5/0F", row, colg, colr); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_swap_mid();
    test_merged();
    test_boundary();
    test_no_req();
    test_write_at_swap();
    test_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
